// File: rtl/sweep_sequencer.sv
// sweep_sequencer: run controller for a single sweep_transition block.
// It drives the sweep block's enable and step tick, counts completed passes
// by watching the two mask corner bits, and ends a run once a programmed
// pass target is reached or when a stop request arrives.
module sweep_sequencer #(
  parameter int WIDTH      = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int PASS_WIDTH = 8,
  parameter int ARM_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  pause_i,
  input  logic [CNT_WIDTH-1:0]  period_i,
  input  logic [PASS_WIDTH-1:0] passes_i,
  input  logic [WIDTH-1:0]      mask_i,
  output logic                  en_o,
  output logic                  tick_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [PASS_WIDTH-1:0] pass_cnt_o
);

  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  period_q, period_d;
  logic [PASS_WIDTH-1:0] passes_q, passes_d;
  logic [PASS_WIDTH-1:0] passCnt_q, passCnt_d;
  logic [CNT_WIDTH-1:0]  tickCnt_q, tickCnt_d;
  logic [ARM_W-1:0]      armCnt_q, armCnt_d;
  logic [1:0]            cPrev_q;
  logic                  en_q, tick_q, busy_q, done_q;

  logic [1:0]            corner;
  logic                  passEvent;
  logic [PASS_WIDTH-1:0] passInc;
  logic                  hitTarget;
  logic [CNT_WIDTH-1:0]  tickNext;
  logic                  tickFire;
  logic                  unusedMaskBits;

  // Only the two corner bits of the mask carry pass information.
  assign corner         = {mask_i[WIDTH-1], mask_i[0]};
  assign unusedMaskBits = ^mask_i;

  // Pass detection: a rising corner in RUN or PAUSE is one pass, even if both corners rise together.
  always_comb begin
    passEvent = 1'b0;
    if ((state_q == S_RUN) || (state_q == S_PAUSE)) begin
      passEvent = |(corner & ~cPrev_q);
    end
    passInc   = (passCnt_q == '1) ? passCnt_q : passCnt_q + PASS_WIDTH'(1);
    hitTarget = passEvent && (passes_q != '0) && (passInc == passes_q);
    tickNext  = (tickCnt_q == period_q) ? '0 : tickCnt_q + CNT_WIDTH'(1);
  end

  // Next-state logic: stop beats completion, completion beats pause.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    passes_d  = passes_q;
    passCnt_d = passCnt_q;
    tickCnt_d = tickCnt_q;
    armCnt_d  = armCnt_q;
    tickFire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          // A zero period would hold tick high continuously, so clamp to 1.
          period_d  = (period_i == '0) ? CNT_WIDTH'(1) : period_i;
          passes_d  = passes_i;
          passCnt_d = '0;
          armCnt_d  = '0;
          state_d   = S_ARM;
        end
      end
      S_ARM: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (armCnt_q == ARM_LAST) begin
          tickCnt_d = '0;
          state_d   = S_RUN;
        end else begin
          armCnt_d = armCnt_q + ARM_W'(1);
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else begin
          if (passEvent) begin
            passCnt_d = passInc;
          end
          if (hitTarget) begin
            state_d = S_DONE;
          end else if (pause_i) begin
            state_d = S_PAUSE;
          end else begin
            tickCnt_d = tickNext;
            tickFire  = (tickNext == period_q);
          end
        end
      end
      S_PAUSE: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else begin
          if (passEvent) begin
            passCnt_d = passInc;
          end
          if (hitTarget) begin
            state_d = S_DONE;
          end else if (!pause_i) begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, run parameters, counters and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q   <= S_IDLE;
      period_q  <= '0;
      passes_q  <= '0;
      passCnt_q <= '0;
      tickCnt_q <= '0;
      armCnt_q  <= '0;
      cPrev_q   <= '0;
      en_q      <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      passes_q  <= passes_d;
      passCnt_q <= passCnt_d;
      tickCnt_q <= tickCnt_d;
      armCnt_q  <= armCnt_d;
      cPrev_q   <= corner;
      en_q      <= (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_PAUSE);
      tick_q    <= tickFire;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign en_o       = en_q;
  assign tick_o     = tick_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_cnt_o = passCnt_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer: self-checking bench for sweep_sequencer.
// Expected tick positions and pass counts are queued when stimulus is driven
// and popped when the DUT shows the corresponding output.
module tb_sweep_sequencer;

  localparam int WIDTH      = 4;
  localparam int CNT_WIDTH  = 16;
  localparam int PASS_WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  arstn_i = 1'b0;
  logic                  start_i = 1'b0;
  logic                  stop_i = 1'b0;
  logic                  pause_i = 1'b0;
  logic [CNT_WIDTH-1:0]  period_i = '0;
  logic [PASS_WIDTH-1:0] passes_i = '0;
  logic [WIDTH-1:0]      mask_i = '0;
  logic                  en_o, tick_o, busy_o, done_o;
  logic [PASS_WIDTH-1:0] pass_cnt_o;

  int errors = 0;
  int checks = 0;
  int expTick[$];
  int expPass[$];

  sweep_sequencer #(
    .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .PASS_WIDTH(PASS_WIDTH), .ARM_CYCLES(2)
  ) dut (
    .clk_i(clk), .arstn_i(arstn_i), .start_i(start_i), .stop_i(stop_i),
    .pause_i(pause_i), .period_i(period_i), .passes_i(passes_i), .mask_i(mask_i),
    .en_o(en_o), .tick_o(tick_o), .busy_o(busy_o), .done_o(done_o),
    .pass_cnt_o(pass_cnt_o)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start request with the given run parameters.
  task automatic applyStimulus(input logic [CNT_WIDTH-1:0] period, input logic [PASS_WIDTH-1:0] passes);
    period_i = period;
    passes_i = passes;
    start_i  = 1'b1;
  endtask

  // Reset drives every output low.
  task automatic test_reset();
    arstn_i = 1'b0;
    step();
    step();
    checks++; if (en_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b, expected 0", en_o); end
    checks++; if (tick_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick: got %b, expected 0", tick_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", done_o); end
    checks++; if (pass_cnt_o !== '0) begin errors++; $display("[TB] FAIL reset_passcnt: got %0d, expected 0", pass_cnt_o); end
    arstn_i = 1'b1;
    mask_i  = '0;
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy: got %b, expected 0", busy_o); end
  endtask

  // Basic ticking with period 3 (or a clamped period 0), no pass target.
  task automatic test_tick(input int period, input int lastStep, input string name);
    int gap;
    int firstTick;
    int exp;
    gap       = (period == 0) ? 2 : period + 1;
    firstTick = 2 + gap;
    expTick.delete();
    for (int t = firstTick; t <= lastStep; t += gap) expTick.push_back(t);
    applyStimulus(CNT_WIDTH'(period), '0);
    for (int k = 1; k <= lastStep; k++) begin
      step();
      if (k == 1) begin
        start_i = 1'b0;
        checks++; if (en_o !== 1'b1) begin errors++; $display("[TB] FAIL %s_en_rise: got %b, expected 1", name, en_o); end
      end
      if (tick_o !== 1'b0) begin
        checks++;
        if (expTick.size() == 0) begin
          errors++; $display("[TB] FAIL %s_tick_unexpected: tick at step %0d, expected none", name, k);
        end else begin
          exp = expTick.pop_front();
          if (exp != k) begin errors++; $display("[TB] FAIL %s_tick_pos: got step %0d, expected step %0d", name, k, exp); end
        end
      end
      checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL %s_done: got %b at step %0d, expected 0", name, done_o, k); end
    end
    checks++; if (expTick.size() != 0) begin errors++; $display("[TB] FAIL %s_tick_missing: %0d ticks outstanding, expected 0", name, expTick.size()); end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    checks++; if (en_o !== 1'b0) begin errors++; $display("[TB] FAIL %s_stop_en: got %b, expected 0", name, en_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL %s_stop_busy: got %b, expected 0", name, busy_o); end
  endtask

  // Pass counting to a target of 2, with an ignored corner edge during ARM.
  task automatic test_passes();
    logic [1:0] prevCorner;
    logic [1:0] newCorner;
    logic [WIDTH-1:0] drive;
    int modelCnt;
    int lastSeen;
    int exp;
    int doneStep;
    expPass.delete();
    prevCorner = 2'b00;
    modelCnt   = 0;
    lastSeen   = 0;
    doneStep   = -1;
    applyStimulus(CNT_WIDTH'(9), PASS_WIDTH'(2));
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) start_i = 1'b0;
      if (pass_cnt_o != lastSeen[PASS_WIDTH-1:0]) begin
        checks++;
        if (expPass.size() == 0) begin
          errors++; $display("[TB] FAIL pass_unexpected: got %0d at step %0d, expected no change", pass_cnt_o, k);
        end else begin
          exp = expPass.pop_front();
          if (pass_cnt_o !== PASS_WIDTH'(exp)) begin errors++; $display("[TB] FAIL pass_value: got %0d, expected %0d", pass_cnt_o, exp); end
        end
        lastSeen = int'(pass_cnt_o);
      end
      if (k == doneStep) begin
        checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL pass_done: got %b, expected 1", done_o); end
        checks++; if (en_o !== 1'b0) begin errors++; $display("[TB] FAIL pass_done_en: got %b, expected 0", en_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL pass_done_busy: got %b, expected 1", busy_o); end
      end else begin
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL pass_done_idle: got %b at step %0d, expected 0", done_o, k); end
      end
      if (k == doneStep + 1 && doneStep > 0) begin
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL pass_after_busy: got %b, expected 0", busy_o); end
      end
      drive = mask_i;
      case (k)
        1: drive = 4'b0001;
        4: drive = 4'b0000;
        6: drive = 4'b1000;
        8: drive = 4'b1001;
        default: drive = mask_i;
      endcase
      mask_i = drive;
      newCorner = {drive[WIDTH-1], drive[0]};
      if (k >= 3 && doneStep < 0 && (newCorner & ~prevCorner) != 2'b00) begin
        modelCnt++;
        expPass.push_back(modelCnt);
        if (modelCnt == 2) doneStep = k + 1;
      end
      prevCorner = newCorner;
    end
    checks++; if (expPass.size() != 0) begin errors++; $display("[TB] FAIL pass_missing: %0d outstanding, expected 0", expPass.size()); end
    checks++; if (pass_cnt_o !== 8'd2) begin errors++; $display("[TB] FAIL pass_hold: got %0d, expected 2", pass_cnt_o); end
    mask_i = '0;
    step();
  endtask

  // Pause for 7 cycles starting at counter value 2 with period 5.
  task automatic test_pause();
    int exp;
    expTick.delete();
    expTick.push_back(8);
    expTick.push_back(22);
    expTick.push_back(28);
    expTick.push_back(34);
    applyStimulus(CNT_WIDTH'(5), '0);
    for (int k = 1; k <= 36; k++) begin
      step();
      if (k == 1) start_i = 1'b0;
      checks++; if (en_o !== 1'b1) begin errors++; $display("[TB] FAIL pause_en: got %b at step %0d, expected 1", en_o, k); end
      if (tick_o !== 1'b0) begin
        checks++;
        if (expTick.size() == 0) begin
          errors++; $display("[TB] FAIL pause_tick_unexpected: tick at step %0d, expected none", k);
        end else begin
          exp = expTick.pop_front();
          if (exp != k) begin errors++; $display("[TB] FAIL pause_tick_pos: got step %0d, expected step %0d", k, exp); end
        end
      end
      if (k == 11) pause_i = 1'b1;
      if (k == 18) pause_i = 1'b0;
    end
    checks++; if (expTick.size() != 0) begin errors++; $display("[TB] FAIL pause_tick_missing: %0d outstanding, expected 0", expTick.size()); end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL pause_stop_busy: got %b, expected 0", busy_o); end
  endtask

  // Start while busy is ignored; stop beats a final pass edge.
  task automatic test_stop_priority();
    int exp;
    expTick.delete();
    expTick.push_back(6);
    expTick.push_back(10);
    applyStimulus(CNT_WIDTH'(3), PASS_WIDTH'(1));
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 1) start_i = 1'b0;
      if (k == 4) applyStimulus(CNT_WIDTH'(0), PASS_WIDTH'(5));
      if (k == 5) start_i = 1'b0;
      if (tick_o !== 1'b0) begin
        checks++;
        if (expTick.size() == 0) begin
          errors++; $display("[TB] FAIL busy_start_tick_unexpected: tick at step %0d, expected none", k);
        end else begin
          exp = expTick.pop_front();
          if (exp != k) begin errors++; $display("[TB] FAIL busy_start_tick_pos: got step %0d, expected step %0d", k, exp); end
        end
      end
    end
    checks++; if (expTick.size() != 0) begin errors++; $display("[TB] FAIL busy_start_tick_missing: %0d outstanding, expected 0", expTick.size()); end
    mask_i = 4'b0001;
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    checks++; if (en_o !== 1'b0) begin errors++; $display("[TB] FAIL stop_en: got %b, expected 0", en_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL stop_done: got %b, expected 0", done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL stop_busy: got %b, expected 0", busy_o); end
    checks++; if (tick_o !== 1'b0) begin errors++; $display("[TB] FAIL stop_tick: got %b, expected 0", tick_o); end
    step();
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL stop_done_late: got %b, expected 0", done_o); end
    mask_i = '0;
    step();
  endtask

  // Reset mid-run, then a clean run to a target of 1.
  task automatic test_reset_midrun();
    int exp;
    applyStimulus(CNT_WIDTH'(2), PASS_WIDTH'(3));
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) start_i = 1'b0;
      if (k == 3) mask_i = 4'b0001;
      if (k == 4) begin
        checks++; if (pass_cnt_o !== 8'd1) begin errors++; $display("[TB] FAIL midrun_pass: got %0d, expected 1", pass_cnt_o); end
      end
    end
    arstn_i = 1'b0;
    step();
    arstn_i = 1'b1;
    mask_i  = '0;
    checks++; if (en_o !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_en: got %b, expected 0", en_o); end
    checks++; if (tick_o !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_tick: got %b, expected 0", tick_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_busy: got %b, expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_done: got %b, expected 0", done_o); end
    checks++; if (pass_cnt_o !== '0) begin errors++; $display("[TB] FAIL midrun_reset_pass: got %0d, expected 0", pass_cnt_o); end
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrun_idle_busy: got %b, expected 0", busy_o); end
    expTick.delete();
    expTick.push_back(4);
    expTick.push_back(6);
    applyStimulus(CNT_WIDTH'(1), PASS_WIDTH'(1));
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin
        start_i = 1'b0;
        checks++; if (pass_cnt_o !== '0) begin errors++; $display("[TB] FAIL rerun_pass_start: got %0d, expected 0", pass_cnt_o); end
        checks++; if (en_o !== 1'b1) begin errors++; $display("[TB] FAIL rerun_en: got %b, expected 1", en_o); end
      end
      if (tick_o !== 1'b0) begin
        checks++;
        if (expTick.size() == 0) begin
          errors++; $display("[TB] FAIL rerun_tick_unexpected: tick at step %0d, expected none", k);
        end else begin
          exp = expTick.pop_front();
          if (exp != k) begin errors++; $display("[TB] FAIL rerun_tick_pos: got step %0d, expected step %0d", k, exp); end
        end
      end
      if (k == 6) mask_i = 4'b0001;
      if (k == 7) begin
        checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL rerun_done: got %b, expected 1", done_o); end
        checks++; if (pass_cnt_o !== 8'd1) begin errors++; $display("[TB] FAIL rerun_pass: got %0d, expected 1", pass_cnt_o); end
        checks++; if (en_o !== 1'b0) begin errors++; $display("[TB] FAIL rerun_done_en: got %b, expected 0", en_o); end
      end
      if (k == 8) begin
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rerun_busy: got %b, expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL rerun_done_pulse: got %b, expected 0", done_o); end
      end
    end
    checks++; if (expTick.size() != 0) begin errors++; $display("[TB] FAIL rerun_tick_missing: %0d outstanding, expected 0", expTick.size()); end
    mask_i = '0;
    step();
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_tick(3, 19, "period3");
    test_tick(0, 11, "period0");
    test_passes();
    test_pause();
    test_stop_priority();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
